// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator: product width,
// the ACCUM/HOLD state encoding and the sign-extension width helper.
package product_acc_pkg;

  localparam int PROD_W = 18;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } accState_e;

  // Number of copies of the product sign bit needed to reach the accumulator width.
  function automatic int sextWidth(input int accW);
    return accW - PROD_W;
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / sum-out handshake bundle. The accumulator uses the slave
// modport; the producer/consumer side uses master.
interface product_accumulator_if #(
  parameter int ACC_W = 20
);
  import product_acc_pkg::*;

  logic signed [PROD_W-1:0] Product_In;
  logic                     Product_Valid;
  logic                     Product_Ready;
  logic signed [ACC_W-1:0]  Acc_Out;
  logic                     Acc_Valid;
  logic                     Acc_Ready;
  logic                     Overflow;

  modport slave (
    input  Product_In, Product_Valid, Acc_Ready,
    output Product_Ready, Acc_Out, Acc_Valid, Overflow
  );

  modport master (
    output Product_In, Product_Valid, Acc_Ready,
    input  Product_Ready, Acc_Out, Acc_Valid, Overflow
  );

endinterface

// File: rtl/product_accumulator_add.sv
// Combinational accumulator adder with exact-range overflow detection.
// Define PRODUCT_ACC_SATURATE_EN to clamp out-of-range results; otherwise they wrap.
module acc_add
  import product_acc_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [PROD_W-1:0] prod_i,
  output logic signed [ACC_W-1:0]  sum_o,
  output logic                     ovf_o
);

  localparam int EXT_W = sextWidth(ACC_W);

  // One guard bit above ACC_W holds the exact sum of two in-range operands.
  logic [ACC_W:0] exactSum;

  assign exactSum = {acc_i[ACC_W-1], acc_i} + {{(EXT_W + 1){prod_i[PROD_W-1]}}, prod_i};
  assign ovf_o    = exactSum[ACC_W] ^ exactSum[ACC_W-1];

`ifdef PRODUCT_ACC_SATURATE_EN
  always_comb begin
    sum_o = exactSum[ACC_W-1:0];
    if (ovf_o) begin
      sum_o = exactSum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    end
  end
`else
  assign sum_o = exactSum[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums TERMS signed products into one ACC_W result, holding it until consumed.
// Saturation instead of wrap-around is enabled by PRODUCT_ACC_SATURATE_EN.
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int TERMS = 8,
  parameter int ACC_W = 20
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Clear,
  product_accumulator_if.slave  bus
);

  localparam int CNT_W = $clog2(TERMS);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LAST_TERM = cnt_t'(TERMS - 1);

  if (TERMS < 2 || TERMS > 256) begin : gBadTerms
    $error("product_accumulator: TERMS must lie in 2..256");
  end
  if (ACC_W < 19 || ACC_W > 32) begin : gBadAccW
    $error("product_accumulator: ACC_W must lie in 19..32");
  end

  accState_e               state_q;
  logic signed [ACC_W-1:0] acc_q;
  cnt_t                    cnt_q;
  logic                    ovf_q;
  logic                    ready_q;
  logic                    valid_q;

  logic signed [ACC_W-1:0] acc_d;
  logic                    addOvf;
  logic                    accept;

  assign accept = bus.Product_Valid && ready_q;

  acc_add #(
    .ACC_W(ACC_W)
  ) uAdd (
    .acc_i (acc_q),
    .prod_i(bus.Product_In),
    .sum_o (acc_d),
    .ovf_o (addOvf)
  );

  // Ready stays low through reset and rises on the first edge afterwards.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (Clear) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          ready_q <= 1'b1;
          if (accept) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | addOvf;
            if (cnt_q == LAST_TERM) begin
              cnt_q   <= '0;
              state_q <= HOLD;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.Acc_Ready) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ACCUM;
          ready_q <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Product_Ready = ready_q;
  assign bus.Acc_Valid     = valid_q;
  assign bus.Acc_Out       = acc_q;
  assign bus.Overflow      = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator: table-driven sums, hand-written corner
// sequences and a random-gap run, all checked through an expected-result queue.
module tb_product_accumulator;

  localparam int  TERMS   = 8;
  localparam int  ACC_W   = 20;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));
  localparam longint ACC_MOD = longint'(1) <<< ACC_W;
  localparam int  NUM_VEC = 7;

  typedef struct {
    int sum;
    bit ovf;
  } exp_t;

  typedef struct {
    int prod[TERMS];
    int expSum;
    bit expOvf;
  } vec_t;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  logic Clear = 1'b0;

  exp_t expQ[$];
  vec_t vecs[NUM_VEC];
  int   checks    = 0;
  int   failures  = 0;
  int   readyMode = 1;

  product_accumulator_if #(.ACC_W(ACC_W)) bus ();

  product_accumulator #(
    .TERMS(TERMS),
    .ACC_W(ACC_W)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .Clear(Clear),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  // Consumer: 0 = never ready, 1 = always ready, otherwise ready ~75% of cycles.
  always @(posedge Clk) begin
    #1;
    case (readyMode)
      0:       bus.Acc_Ready = 1'b0;
      1:       bus.Acc_Ready = 1'b1;
      default: bus.Acc_Ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Results are compared when the consumer is about to take them.
  always @(negedge Clk) begin
    exp_t e;
    if (Rst_n && bus.Acc_Valid === 1'b1 && bus.Acc_Ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_result actual=%0d expected=none", int'(bus.Acc_Out));
      end else begin
        e = expQ.pop_front();
        checkOutput("sum", int'(bus.Acc_Out), e.sum);
        checkOutput("overflow", int'(bus.Overflow), int'(e.ovf));
      end
    end
  end

  function automatic exp_t modelSum(input int prods[TERMS]);
    longint acc;
    exp_t   r;
    acc   = 0;
    r.ovf = 1'b0;
    for (int i = 0; i < TERMS; i++) begin
      acc += prods[i];
      if (acc > ACC_MAX || acc < ACC_MIN) begin
        r.ovf = 1'b1;
`ifdef PRODUCT_ACC_SATURATE_EN
        acc = (acc > ACC_MAX) ? ACC_MAX : ACC_MIN;
`else
        acc = (acc > ACC_MAX) ? acc - ACC_MOD : acc + ACC_MOD;
`endif
      end
    end
    r.sum = int'(acc);
    return r;
  endfunction

  task automatic sendProduct(input int p, input int gap);
    int n;
    bit took;
    repeat (gap) begin
      @(posedge Clk);
      #1;
    end
    bus.Product_In    = 18'(p);
    bus.Product_Valid = 1'b1;
    n    = 0;
    took = 1'b0;
    while (!took && n < 200) begin
      @(negedge Clk);
      took = bus.Product_Ready;
      @(posedge Clk);
      #1;
      n++;
    end
    bus.Product_Valid = 1'b0;
    if (!took) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=not_accepted expected=accepted");
    end
  endtask

  task automatic applyStimulus(input int prods[TERMS], input exp_t e, input bit randomGaps);
    expQ.push_back(e);
    for (int i = 0; i < TERMS; i++) begin
      sendProduct(prods[i], (randomGaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    end
  endtask

  task automatic waitDrained(input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || bus.Acc_Valid) && n < 100) begin
      @(posedge Clk);
      #1;
      n++;
    end
    checkOutput(name, expQ.size(), 0);
  endtask

  task automatic setReadyMode(input int mode);
    readyMode = mode;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int   p[TERMS];
    exp_t e;

    #5_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   p[TERMS];
    exp_t e;

    bus.Product_In    = '0;
    bus.Product_Valid = 1'b0;

    vecs[0].prod = '{default: 100};
    vecs[0].expSum = 800;     vecs[0].expOvf = 1'b0;
    vecs[1].prod = '{1, 2, 3, 4, 5, 6, 7, 8};
    vecs[1].expSum = 36;      vecs[1].expOvf = 1'b0;
    vecs[2].prod = '{default: 65536};
`ifdef PRODUCT_ACC_SATURATE_EN
    vecs[2].expSum = 524287;
`else
    vecs[2].expSum = -524288;
`endif
    vecs[2].expOvf = 1'b1;
    vecs[3].prod = '{default: -65280};
    vecs[3].expSum = -522240; vecs[3].expOvf = 1'b0;
    vecs[4].prod = '{65536, 65536, 65536, 65536, 65536, 65536, 65536, -65280};
    vecs[4].expSum = 393472;  vecs[4].expOvf = 1'b0;
    vecs[5].prod = '{default: 0};
    vecs[5].expSum = 0;       vecs[5].expOvf = 1'b0;
    vecs[6].prod = '{12345, -54321, 65536, -65280, 1, -1, 30000, -7};
    vecs[6].expSum = -11727;  vecs[6].expOvf = 1'b0;

    // Reset state and the first-edge rise of Product_Ready.
    #12;
    checkOutput("reset_acc", int'(bus.Acc_Out), 0);
    checkOutput("reset_valid", int'(bus.Acc_Valid), 0);
    checkOutput("reset_ovf", int'(bus.Overflow), 0);
    checkOutput("reset_ready", int'(bus.Product_Ready), 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    checkOutput("ready_before_edge", int'(bus.Product_Ready), 0);
    @(posedge Clk);
    #1;
    checkOutput("ready_after_edge", int'(bus.Product_Ready), 1);

    // Table vectors, back-to-back, consumer always ready.
    setReadyMode(1);
    for (int v = 0; v < NUM_VEC; v++) begin
      e.sum = vecs[v].expSum;
      e.ovf = vecs[v].expOvf;
      applyStimulus(vecs[v].prod, e, 1'b0);
      checkOutput("valid_latency", int'(bus.Acc_Valid), 1);
      checkOutput("hold_not_ready", int'(bus.Product_Ready), 0);
      @(posedge Clk);
      #1;
      checkOutput("consumed_valid", int'(bus.Acc_Valid), 0);
      checkOutput("consumed_ready", int'(bus.Product_Ready), 1);
      checkOutput("consumed_acc", int'(bus.Acc_Out), 0);
    end
    waitDrained("table_drained");

    // Held result stays stable while the consumer stalls; products offered in HOLD are ignored.
    setReadyMode(0);
    for (int i = 0; i < TERMS; i++) p[i] = (i % 2 == 0) ? -256 : 255;
    e.sum = -4;
    e.ovf = 1'b0;
    applyStimulus(p, e, 1'b0);
    bus.Product_In    = 18'(999);
    bus.Product_Valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      checkOutput("stall_acc", int'(bus.Acc_Out), -4);
      checkOutput("stall_valid", int'(bus.Acc_Valid), 1);
      checkOutput("stall_ready", int'(bus.Product_Ready), 0);
    end
    @(posedge Clk);
    #1;
    bus.Product_Valid = 1'b0;
    setReadyMode(1);
    waitDrained("stall_drained");
    checkOutput("stall_after_acc", int'(bus.Acc_Out), 0);

    // Clear after three accepts drops the product offered with it.
    for (int i = 0; i < 3; i++) sendProduct(7, 0);
    checkOutput("partial_acc", int'(bus.Acc_Out), 21);
    Clear             = 1'b1;
    bus.Product_In    = 18'(500);
    bus.Product_Valid = 1'b1;
    @(posedge Clk);
    #1;
    Clear             = 1'b0;
    bus.Product_Valid = 1'b0;
    checkOutput("clear_acc", int'(bus.Acc_Out), 0);
    checkOutput("clear_ready", int'(bus.Product_Ready), 1);
    p = '{default: 1};
    e.sum = 8;
    e.ovf = 1'b0;
    applyStimulus(p, e, 1'b0);
    waitDrained("clear_drained");

    // Clear while holding an overflowed result.
    setReadyMode(0);
    for (int i = 0; i < TERMS; i++) sendProduct(65536, 0);
    checkOutput("hold_ovf", int'(bus.Overflow), 1);
    Clear = 1'b1;
    @(posedge Clk);
    #1;
    Clear = 1'b0;
    checkOutput("clear_hold_ovf", int'(bus.Overflow), 0);
    checkOutput("clear_hold_valid", int'(bus.Acc_Valid), 0);
    checkOutput("clear_hold_acc", int'(bus.Acc_Out), 0);
    setReadyMode(1);

    // Asynchronous reset in the middle of a sum.
    for (int i = 0; i < 4; i++) sendProduct(1000, 0);
    #2;
    Rst_n = 1'b0;
    #1;
    checkOutput("async_rst_acc", int'(bus.Acc_Out), 0);
    checkOutput("async_rst_valid", int'(bus.Acc_Valid), 0);
    checkOutput("async_rst_ready", int'(bus.Product_Ready), 0);
    checkOutput("async_rst_ovf", int'(bus.Overflow), 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    checkOutput("rst_release_ready", int'(bus.Product_Ready), 1);
    p = '{default: -3};
    e.sum = -24;
    e.ovf = 1'b0;
    applyStimulus(p, e, 1'b0);
    waitDrained("rst_drained");

    // Random products with input gaps and a stalling consumer.
    setReadyMode(2);
    for (int s = 0; s < 1000; s++) begin
      for (int i = 0; i < TERMS; i++) p[i] = int'($urandom_range(0, 130816)) - 65280;
      e = modelSum(p);
      applyStimulus(p, e, 1'b1);
    end
    setReadyMode(1);
    waitDrained("random_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter TERMS, default 8, products summed per result (2..256).
REQ-002 SHALL have parameter ACC_W, default 20, accumulator width in bits (19..32).
REQ-003 SHALL have port Clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Product_In  input  18  signed two's-complement product from the 9x9 Booth multiplier.
REQ-006 SHALL have port Product_Valid  input  1  Product_In valid this cycle.
REQ-007 SHALL have port Product_Ready  output  1  block accepts Product_In this cycle.
REQ-008 SHALL have port Clear  input  1  synchronous abort of the current sum.
REQ-009 SHALL have port Acc_Out  output  ACC_W  signed sum of TERMS products.
REQ-010 SHALL have port Acc_Valid  output  1  Acc_Out holds a completed sum.
REQ-011 SHALL have port Acc_Ready  input  1  consumer takes Acc_Out.
REQ-012 SHALL have port Overflow  output  1  current or held sum exceeded the ACC_W signed range.

Function
REQ-013 SHALL implement two states: ACCUM (Product_Ready=1, Acc_Valid=0) and HOLD (Product_Ready=0, Acc_Valid=1).
REQ-014 SHALL accept a product only on a cycle where Product_Valid and Product_Ready are both 1.
REQ-015 On accept, SHALL sign-extend Product_In to ACC_W, add it to the accumulator and increment the term counter.
REQ-016 When the accepted product is term TERMS, SHALL move to HOLD on the next edge, with Acc_Out equal to the full sum.
REQ-017 In HOLD, Acc_Out and Overflow SHALL stay stable until Acc_Ready=1.
REQ-018 On Acc_Ready=1 in HOLD, SHALL zero the accumulator, counter and Overflow and return to ACCUM; the first new product can be accepted one cycle later.
REQ-019 Throughput SHALL be one product per cycle in ACCUM; a TERMS-product sum costs TERMS+1 cycles plus consumer wait.
REQ-020 Overflow SHALL set when any addition's exact result falls outside [-2^(ACC_W-1), 2^(ACC_W-1)-1], and SHALL remain set until the sum is consumed or cleared.
REQ-021 Clear=1 SHALL take priority over every other event: it zeros the accumulator, counter and Overflow, enters ACCUM, and drops any product offered in the same cycle.
REQ-022 Acc_Ready SHALL be ignored in ACCUM, and Product_Valid SHALL be ignored in HOLD.
REQ-023 Acc_Out SHALL read the running partial sum in ACCUM.

Reset
REQ-024 Rst_n=0 SHALL asynchronously force state ACCUM, accumulator 0, counter 0, Acc_Out=0, Acc_Valid=0, Overflow=0 and Product_Ready=0.
REQ-025 Product_Ready SHALL rise on the first Clk edge after Rst_n deasserts.
REQ-026 Reset mid-sum SHALL discard the partial sum without emitting a result.

Configuration
REQ-027 With PRODUCT_ACC_SATURATE_EN defined, an out-of-range addition SHALL clamp the accumulator to the nearest signed limit, and later additions SHALL start from the clamped value.
REQ-028 Without PRODUCT_ACC_SATURATE_EN, additions SHALL wrap modulo 2^ACC_W.
REQ-029 Overflow SHALL behave identically in both builds.

Structure
REQ-030 Package product_acc_pkg SHALL hold PROD_W=18, the state enumeration (ACCUM, HOLD) and the sign-extension width constant.
REQ-031 A sub-module acc_add SHALL be instantiated, containing the combinational ACC_W adder, overflow detect and optional saturation.
REQ-032 The counter width SHALL be clog2(TERMS) and be derived from TERMS.

Verification (defaults TERMS=8, ACC_W=20)
REQ-033 Eight back-to-back products of +100, Acc_Ready=1 -> Acc_Valid on the cycle after the eighth accept, Acc_Out=800, Overflow=0.
REQ-034 Products -256,+255 alternating, with Acc_Ready held 0 for 5 cycles -> Acc_Out=-4 held stable, Product_Ready=0 throughout HOLD.
REQ-035 Eight products of +65536 (from -256*-256) -> Overflow=1; Acc_Out=524287 with the macro, -524288 without it.
REQ-036 Clear asserted together with Product_Valid after 3 accepts -> product dropped, Acc_Out=0; a following 8 x +1 yields 8.
REQ-037 Rst_n pulsed low mid-sum, asynchronously between edges -> outputs zero immediately; no Acc_Valid pulse occurs.
REQ-038 Random Product_Valid gaps over 1000 sums -> every result matches a reference-model sum; no product is lost or duplicated.
